// File: rtl/matmul_instr_seq_if.sv
// Instruction stream handshake between matmul_instr_seq and the matrix ALU.
// The sequencer drives instr/instr_valid and the ALU side returns instr_ready.
interface matmul_instr_seq_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready
  );
endinterface

// File: rtl/matmul_instr_seq.sv
// Emits the full MIPS-format program for C = A x B (N x N, row-major) into the matrix ALU,
// one word per handshake, ordered row-major over C and ascending over k per element.
module matmul_instr_seq #(
  parameter int unsigned N      = 3,
  parameter int unsigned A_BASE = 0,
  parameter int unsigned B_BASE = 9,
  parameter int unsigned C_BASE = 18
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  matmul_instr_seq_if.master         bus,
  output logic                       busy,
  output logic                       done
);

  localparam logic [31:0] InstrClr = 32'h22F30000;
  localparam logic [31:0] InstrMul = 32'h02119018;
  localparam logic [31:0] InstrAcc = 32'h02539820;
  localparam logic [2:0]  LastIdx  = 3'(N - 1);

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StLda,
    StLdb,
    StMul,
    StAcc,
    StStc,
    StFin
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  i_q, i_d;
  logic [2:0]  j_q, j_d;
  logic [2:0]  k_q, k_d;
  logic        valid_q;
  logic [31:0] instr_q;
  logic        busy_q;
  logic        done_q;
  logic        adv;
  logic        emits;

  // Word that a given state presents for the given loop indices.
  function automatic logic [31:0] encode(state_e st, logic [2:0] ci, logic [2:0] cj,
                                         logic [2:0] ck);
    logic [15:0] a_addr;
    logic [15:0] b_addr;
    logic [15:0] c_addr;
    logic [31:0] word;
    a_addr = 16'(A_BASE + 32'(ci) * N + 32'(ck));
    b_addr = 16'(B_BASE + 32'(ck) * N + 32'(cj));
    c_addr = 16'(C_BASE + 32'(ci) * N + 32'(cj));
    case (st)
      StClr:   word = InstrClr;
      StLda:   word = {16'h8EF0, a_addr};
      StLdb:   word = {16'h8EF1, b_addr};
      StMul:   word = InstrMul;
      StAcc:   word = InstrAcc;
      StStc:   word = {16'hAEF3, c_addr};
      default: word = 32'h0;
    endcase
    return word;
  endfunction

  // IDLE waits on start, FIN always moves on, every emitting state waits on a handshake.
  always_comb begin
    adv = 1'b0;
    case (state_q)
      StIdle:  adv = start;
      StFin:   adv = 1'b1;
      default: adv = valid_q & bus.instr_ready;
    endcase
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    case (state_q)
      StIdle: if (start) state_d = StClr;
      StClr:  state_d = StLda;
      StLda:  state_d = StLdb;
      StLdb:  state_d = StMul;
      StMul:  state_d = StAcc;
      StAcc: begin
        if (k_q < LastIdx) begin
          k_d     = k_q + 3'd1;
          state_d = StLda;
        end else begin
          state_d = StStc;
        end
      end
      StStc: begin
        if (i_q == LastIdx && j_q == LastIdx) begin
          state_d = StFin;
        end else begin
          k_d     = 3'd0;
          state_d = StClr;
          if (j_q < LastIdx) begin
            j_d = j_q + 3'd1;
          end else begin
            j_d = 3'd0;
            i_d = i_q + 3'd1;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
        i_d     = 3'd0;
        j_d     = 3'd0;
        k_d     = 3'd0;
      end
      default: state_d = StIdle;
    endcase
  end

  assign emits = (state_d != StIdle) && (state_d != StFin);

  // Outputs are registered alongside the state so instr always matches the state it encodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      i_q     <= 3'd0;
      j_q     <= 3'd0;
      k_q     <= 3'd0;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (adv) begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      valid_q <= emits;
      instr_q <= encode(state_d, i_d, j_d, k_d);
      busy_q  <= emits;
      done_q  <= (state_d == StFin);
    end
  end

  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_matmul_instr_seq.sv
// Directed bench for matmul_instr_seq: reset, full N=3 stream, backpressure, ignored starts,
// mid-program reset and the N=1 program.
module tb_matmul_instr_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start3 = 1'b0;
  logic start1 = 1'b0;
  logic busy3, done3, busy1, done1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp3[$];
  logic [31:0] cyc_word[512];

  matmul_instr_seq_if bus3 ();
  matmul_instr_seq_if bus1 ();

  matmul_instr_seq #(
    .N(3)
  ) dut3 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start3),
    .bus  (bus3),
    .busy (busy3),
    .done (done3)
  );

  matmul_instr_seq #(
    .N     (1),
    .A_BASE(0),
    .B_BASE(1),
    .C_BASE(2)
  ) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start1),
    .bus  (bus1),
    .busy (busy1),
    .done (done1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference program written as the plain loop nest over C elements.
  task automatic build_model(input int n, input int ab, input int bb, input int cb);
    exp3.delete();
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        exp3.push_back(32'h22F30000);
        for (int k = 0; k < n; k++) begin
          exp3.push_back({16'h8EF0, 16'(ab + i * n + k)});
          exp3.push_back({16'h8EF1, 16'(bb + k * n + j)});
          exp3.push_back(32'h02119018);
          exp3.push_back(32'h02539820);
        end
        exp3.push_back({16'hAEF3, 16'(cb + i * n + j)});
      end
    end
  endtask

  // Starts dut3 and consumes its stream; optional stall, extra start and early abort.
  task automatic run3(input int stall_hs, input int stall_len, input int start_cyc,
                      input int abort_hs, output int hs, output int done_cyc);
    int stalled;
    hs       = 0;
    done_cyc = -1;
    stalled  = 0;
    for (int c = 0; c < 512; c++) cyc_word[c] = 32'h0;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      if (done3) begin
        done_cyc = cyc;
        check("busy_at_done", {31'b0, busy3}, 32'd0);
        check("valid_at_done", {31'b0, bus3.instr_valid}, 32'd0);
        break;
      end
      if (abort_hs >= 0 && hs == abort_hs) return;
      bus3.instr_ready = 1'b1;
      if (!bus3.instr_valid) begin
        check("valid_gap", {31'b0, bus3.instr_valid}, 32'd1);
      end else begin
        cyc_word[cyc] = bus3.instr;
        if (hs >= exp3.size()) begin
          check("extra_word", hs, exp3.size());
          hs++;
        end else if (hs == stall_hs && stalled < stall_len) begin
          bus3.instr_ready = 1'b0;
          stalled++;
          check("stall_hold", bus3.instr, exp3[hs]);
        end else begin
          check("stream", bus3.instr, exp3[hs]);
          hs++;
        end
      end
      start3 = (cyc == start_cyc);
      tick();
      start3 = 1'b0;
    end
  endtask

  logic [31:0] n1_words[6];

  initial begin
    int hs;
    int dc;

    bus3.instr_ready = 1'b0;
    bus1.instr_ready = 1'b0;
    #1 rst_n = 1'b0;

    // Reset held with random inputs.
    for (int c = 0; c < 6; c++) begin
      start3           = 1'($urandom_range(0, 1));
      start1           = 1'($urandom_range(0, 1));
      bus3.instr_ready = 1'($urandom_range(0, 1));
      bus1.instr_ready = 1'($urandom_range(0, 1));
      tick();
      check("rst_outs3", {bus3.instr, bus3.instr_valid, busy3, done3}, 35'd0);
      check("rst_outs1", {bus1.instr_valid, busy1, done1, bus1.instr[28:0]}, 32'd0);
    end
    start3 = 1'b0;
    start1 = 1'b0;
    bus1.instr_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("idle_after_rst", {bus3.instr_valid, busy3, done3}, 32'd0);

    // Baseline N=3 run.
    build_model(3, 0, 9, 18);
    run3(-1, 0, -1, -1, hs, dc);
    check("cyc1", cyc_word[1], 32'h22F30000);
    check("cyc2", cyc_word[2], 32'h8EF00000);
    check("cyc3", cyc_word[3], 32'h8EF10009);
    check("cyc4", cyc_word[4], 32'h02119018);
    check("cyc5", cyc_word[5], 32'h02539820);
    check("cyc6", cyc_word[6], 32'h8EF00001);
    check("cyc14", cyc_word[14], 32'hAEF30012);
    check("cyc126", cyc_word[126], 32'hAEF3001A);
    check("base_hs", hs, 32'd126);
    check("base_done_cyc", dc, 32'd127);
    tick();
    check("base_idle", {bus3.instr_valid, busy3, done3}, 32'd0);

    // Backpressure on word 3 for 5 cycles.
    run3(2, 5, -1, -1, hs, dc);
    check("bp_hs", hs, 32'd126);
    check("bp_done_cyc", dc, 32'd132);
    tick();

    // Start while busy, then start during FIN; both ignored.
    run3(-1, 0, 50, -1, hs, dc);
    check("midstart_hs", hs, 32'd126);
    check("midstart_done_cyc", dc, 32'd127);
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    check("fin_start_ignored", {bus3.instr_valid, busy3, done3}, 32'd0);
    tick();
    check("fin_start_still_idle", {bus3.instr_valid, busy3}, 32'd0);

    // Rerun after done gives an identical stream.
    run3(-1, 0, -1, -1, hs, dc);
    check("rerun_hs", hs, 32'd126);
    check("rerun_done_cyc", dc, 32'd127);
    tick();

    // Reset mid-program at handshake 40.
    run3(-1, 0, -1, 40, hs, dc);
    check("abort_hs", hs, 32'd40);
    check("abort_busy_before", {31'b0, busy3}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_clear", {bus3.instr, bus3.instr_valid, busy3, done3}, 35'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_abort_idle", {bus3.instr_valid, busy3, done3}, 32'd0);
    run3(-1, 0, -1, -1, hs, dc);
    check("post_abort_first", cyc_word[1], 32'h22F30000);
    check("post_abort_hs", hs, 32'd126);
    check("post_abort_done_cyc", dc, 32'd127);
    tick();

    // N=1 instance.
    n1_words[0] = 32'h22F30000;
    n1_words[1] = 32'h8EF00000;
    n1_words[2] = 32'h8EF10001;
    n1_words[3] = 32'h02119018;
    n1_words[4] = 32'h02539820;
    n1_words[5] = 32'hAEF30002;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check("n1_valid", {31'b0, bus1.instr_valid}, 32'd1);
      check("n1_word", bus1.instr, n1_words[c]);
      tick();
    end
    check("n1_done", {bus1.instr_valid, busy1, done1}, 32'b001);
    tick();
    check("n1_idle", {bus1.instr_valid, busy1, done1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_instr_seq.md
# matmul_instr_seq

Instruction sequencer that sits directly upstream of the matrix ALU (`alu_Matrix`). On a start pulse it emits, one 32-bit MIPS-format word per accepted handshake, the complete program that computes C = A × B for N×N matrices held in the ALU's data memory. It replaces hand-written instruction streams, and its output connects straight to the ALU's `instr` input. Ordering is row-major over C and, within each C element, ascending over k.

## Interface
Parameters:
- `N`, default 3: matrix dimension. Legal range 1..8.
- `A_BASE`, default 0: word address of A[0][0]. A is stored row-major.
- `B_BASE`, default 9: word address of B[0][0]. B is stored row-major.
- `C_BASE`, default 18: word address of C[0][0]. C is stored row-major.
- Legality: every generated address must be ≤ 16'hFFFF.

Ports:
- `clk`  in  1: the only clock. All logic is on the rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `start`  in  1: one-cycle request to begin a program. Sampled only in IDLE.
- `instr_ready`  in  1: downstream accepts `instr` this cycle.
- `instr_valid`  out  1: `instr` holds a valid instruction.
- `instr`  out  32: registered instruction word.
- `busy`  out  1: high from the cycle after start is accepted until the cycle `done` rises.
- `done`  out  1: one-cycle pulse after the final store is accepted.

## Operation
- Register conventions are fixed: base register $23 (10111), s0 = 16, s1 = 17, s2 = 18, s3 = 19.
- Encodings, where imm is a 16-bit zero-extended address:
  - CLR: addi s3,$23,0 = 32'h22F30000.
  - LDA: lw s0,imm(\$23) = {16'h8EF0, A_BASE + i·N + k}.
  - LDB: lw s1,imm(\$23) = {16'h8EF1, B_BASE + k·N + j}.
  - MUL: s2 = s0·s1 = 32'h02119018.
  - ACC: s3 = s2 + s3 = 32'h02539820.
  - STC: sw s3,imm(\$23) = {16'hAEF3, C_BASE + i·N + j}.
- State machine states: IDLE, CLR, LDA, LDB, MUL, ACC, STC, FIN.
- Counters: i, j, k, each 3 bits, reset to 0.
- Transitions. Each transition out of CLR..STC occurs only on a handshake (`instr_valid` & `instr_ready`).
  - IDLE → CLR when `start`=1.
  - CLR → LDA.
  - LDA → LDB.
  - LDB → MUL.
  - MUL → ACC.
  - ACC → LDA with k+1 if k<N−1. Otherwise ACC → STC.
  - STC, when not at i=N−1, j=N−1: k←0. If j<N−1, j←j+1. Otherwise j←0, i←i+1. Then go to CLR.
  - STC at i=N−1, j=N−1 → FIN.
  - FIN → IDLE unconditionally. `done`=1 for that cycle. Counters clear.
- Program length is N²·(4N+2) instructions: 126 for N=3, 6 for N=1.
- Address arithmetic is 16-bit unsigned. No wrap is permitted by the parameter legality rule above.
- `start` is ignored in every state other than IDLE, including FIN.
- `instr_ready` is ignored whenever `instr_valid`=0.

## Timing
- Reset values: `instr_valid`=0, `instr`=32'h0, `busy`=0, `done`=0, state=IDLE, i=j=k=0.
- Reset asserted mid-program aborts immediately. The first cycle after deassertion is IDLE with no residual output.
- Start latency: `start` sampled high at edge T gives `instr_valid`=1 with CLR from T+1. `busy` also rises at T+1.
- Throughput: the next word is presented in the cycle after each handshake, so one instruction per cycle while `instr_ready` stays high.
- Backpressure: while `instr_valid`=1 and `instr_ready`=0, `instr` and the state hold stable indefinitely.
- `instr_valid` never drops without a handshake.
- Completion: `instr_valid` falls in the cycle after the final STC handshake. `done` pulses in that same cycle (FIN) and `busy` falls in that same cycle.

## Test plan
- Reset: hold `rst_n`=0 with random `start` and `instr_ready` → all outputs 0. After release, stays IDLE with no `instr_valid`.
- Default N=3, `instr_ready`=1, start at cycle 0. Required words:
  - cycles 1..6: 22F30000, 8EF00000, 8EF10009, 02119018, 02539820, 8EF00001.
  - cycle 14: AEF30012.
  - cycle 126: AEF3001A.
  - cycle 127: `done`=1, `busy`=0.
  - Exactly 126 handshakes.
- Backpressure: drop `instr_ready` for 5 cycles while word 3 (8EF10009) is presented → `instr` is held at 8EF10009 for all 5 cycles. The stream resumes with no skipped or duplicated word, and `done` is delayed by 5 cycles.
- Start while busy or in FIN → ignored and the count stays at 126. A second start in IDLE after `done` reruns an identical stream.
- Reset at handshake 40 → outputs clear asynchronously. A subsequent start produces the full stream from 22F30000.
- N=1, A_BASE=0, B_BASE=1, C_BASE=2 → stream is 22F30000, 8EF00000, 8EF10001, 02119018, 02539820, AEF30002, then `done`.
